// File: rtl/adc_reader_ad7608.sv
// AD7608 serial reader: starts a conversion, waits for BUSY to fall, then
// clocks 72 bits out of both DOUT lines and publishes the upper 16 bits of
// each 18-bit channel result, gated per channel by adc_enable.
module adc_reader_ad7608 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   adc_enable,
  input  logic [1:0]   adc_dout,
  input  logic         adc_busy,
  output logic [127:0] adcdata,
  output logic [7:0]   adcready,
  output logic         cs,
  output logic         convst,
  output logic         sclk_enable
);

  localparam int CONVST_CYCLES = 4;
  localparam int READ_CYCLES   = 72;
  localparam int CH_BITS       = 18;
  localparam int SHIFT_BITS    = 4 * CH_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVST,
    ST_WAIT_BUSY,
    ST_CS_SETUP,
    ST_READ,
    ST_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [6:0]              r_cnt;
  logic [6:0]              w_cnt_next;
  logic                    r_cs;
  logic                    r_convst;
  logic                    r_sclk_enable;
  logic [SHIFT_BITS-1:0]   r_sh_a;
  logic [SHIFT_BITS-1:0]   r_sh_b;
  logic [127:0]            r_adcdata;
  logic [7:0]              r_adcready;
  logic [15:0]             w_ch [8];

  // Next-state and phase counter; the counter restarts at 0 on every state change.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    w_state_next = r_state;
    w_cnt_next   = '0;
    case (r_state)
      ST_IDLE: begin
        if (|adc_enable) w_state_next = ST_CONVST;
      end
      ST_CONVST: begin
        if (r_cnt == 7'(CONVST_CYCLES - 1)) w_state_next = ST_WAIT_BUSY;
        else                                w_cnt_next   = r_cnt + 7'd1;
      end
      ST_WAIT_BUSY: begin
        if (!adc_busy) w_state_next = ST_CS_SETUP;
      end
      ST_CS_SETUP: begin
        w_state_next = ST_READ;
      end
      ST_READ: begin
        if (r_cnt == 7'(READ_CYCLES - 1)) w_state_next = ST_DONE;
        else                              w_cnt_next   = r_cnt + 7'd1;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register plus registered pin outputs decoded from the next state,
  // so cs/convst/sclk_enable line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_cs          <= 1'b1;
      r_convst      <= 1'b0;
      r_sclk_enable <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_cs          <= !((w_state_next == ST_CS_SETUP) || (w_state_next == ST_READ));
      r_convst      <= (w_state_next == ST_CONVST);
      r_sclk_enable <= (w_state_next == ST_READ);
    end
  end

  // Shift both DOUT lines in on every edge that ends an SCLK-producing cycle.
  always_ff @(posedge clk) begin
    // NOTE: the shift registers are reset too, so an aborted read leaves no partial data behind.
    if (!rst_n) begin
      r_sh_a <= '0;
      r_sh_b <= '0;
    end else if (r_sclk_enable) begin
      r_sh_a <= {r_sh_a[SHIFT_BITS-2:0], adc_dout[0]};
      r_sh_b <= {r_sh_b[SHIFT_BITS-2:0], adc_dout[1]};
    end
  end

  // Slice each 18-bit word out of the shift registers, keeping bits [17:2].
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_ch[i]     = r_sh_a[SHIFT_BITS-1-CH_BITS*i -: 16];
      w_ch[i + 4] = r_sh_b[SHIFT_BITS-1-CH_BITS*i -: 16];
    end
  end

  // Publish enabled channels in DONE and strobe adcready for those channels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_adcdata  <= '0;
      r_adcready <= '0;
    end else begin
      r_adcready <= '0;
      if (r_state == ST_DONE) begin
        r_adcready <= adc_enable;
        for (int i = 0; i < 8; i++) begin
          if (adc_enable[i]) r_adcdata[16*i +: 16] <= w_ch[i];
        end
      end
    end
  end

  assign adcdata     = r_adcdata;
  assign adcready    = r_adcready;
  assign cs          = r_cs;
  assign convst      = r_convst;
  assign sclk_enable = r_sclk_enable;

endmodule

// File: tb/tb_adc_reader_ad7608.sv
// Scoreboard bench for adc_reader_ad7608: stimulus pushes expected results,
// a monitor pops them on every adcready strobe and also checks pin timing.
module tb_adc_reader_ad7608;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   adc_enable;
  logic [1:0]   adc_dout;
  logic         adc_busy;
  logic [127:0] adcdata;
  logic [7:0]   adcready;
  logic         cs;
  logic         convst;
  logic         sclk_enable;

  typedef struct {
    logic [7:0]   ready;
    logic [127:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [17:0] words [8];
  logic [15:0] model [8];
  int          busy_len = 16;
  int          n_checks = 0;
  int          n_errors = 0;

  adc_reader_ad7608 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .adc_enable  (adc_enable),
    .adc_dout    (adc_dout),
    .adc_busy    (adc_busy),
    .adcdata     (adcdata),
    .adcready    (adcready),
    .cs          (cs),
    .convst      (convst),
    .sclk_enable (sclk_enable)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit k (0 = first shifted out) of DOUT line 0 (A) or 1 (B).
  function automatic logic line_bit(input int line, input int k);
    logic [17:0] w;
    w = words[line*4 + k/18];
    return w[17 - k%18];
  endfunction

  // ADC serial output: MSB valid once cs is low, next bit after each SCLK.
  initial begin
    int idx;
    idx = 0;
    adc_dout = 2'b00;
    forever begin
      @(posedge clk);
      #2;
      if (cs) begin
        idx = 0;
        adc_dout = 2'b00;
      end else if (idx < 72) begin
        adc_dout = {line_bit(1, idx), line_bit(0, idx)};
        if (sclk_enable) idx++;
      end
    end
  end

  // BUSY model: high for busy_len cycles after each convst rising edge.
  initial begin
    logic prev_cv;
    int   left;
    prev_cv = 1'b0;
    left = 0;
    adc_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (convst && !prev_cv) begin
        adc_busy = 1'b1;
        left = busy_len;
      end else if (left > 0) begin
        left--;
        if (left == 0) adc_busy = 1'b0;
      end
      prev_cv = convst;
    end
  end

  // Monitor: pin invariants each cycle, scoreboard compare on each strobe.
  initial begin
    int   cv_n, cs_n, sc_n;
    logic prev_cv;
    exp_t e;
    cv_n = 0; cs_n = 0; sc_n = 0;
    prev_cv = 1'b0;
    forever begin
      @(negedge clk);
      if (convst && !prev_cv) begin
        cv_n = 0; cs_n = 0; sc_n = 0;
      end
      prev_cv = convst;
      if (convst)      cv_n++;
      if (!cs)         cs_n++;
      if (sclk_enable) sc_n++;
      check("sclk_without_cs", sclk_enable && cs, 0);
      check("convst_with_cs_low", convst && !cs, 0);
      check("busy_with_cs_low", adc_busy && (!cs || sclk_enable), 0);
      if (adcready != 8'h00) begin
        if (exp_q.size() == 0) begin
          check("ready_unexpected", adcready, 0);
        end else begin
          e = exp_q.pop_front();
          check("adcready", adcready, e.ready);
          check("adcdata", adcdata, e.data);
          check("convst_width", cv_n, 4);
          check("cs_low_cycles", cs_n, 73);
          check("sclk_cycles", sc_n, 72);
        end
      end
    end
  end

  task automatic wait_cs(input logic level, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (cs === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic randomize_words();
    for (int i = 0; i < 8; i++) words[i] = 18'($urandom_range(0, 18'h3FFFF));
  endtask

  // One conversion: enable en_start, switch to en_done mid-read if different.
  task automatic run_conv(input logic [7:0] en_start, input logic [7:0] en_done);
    bit   ok;
    exp_t e;
    for (int i = 0; i < 8; i++)
      if (en_done[i]) model[i] = words[i][17:2];
    if (en_done != 8'h00) begin
      e.ready = en_done;
      e.data  = '0;
      for (int i = 0; i < 8; i++) e.data[16*i +: 16] = model[i];
      exp_q.push_back(e);
    end
    adc_enable = en_start;
    wait_cs(1'b0, 1500, ok);
    check("cs_fall_timeout", ok, 1);
    if (!ok) return;
    if (en_done != en_start) begin
      repeat ($urandom_range(2, 60)) @(negedge clk);
      adc_enable = en_done;
    end
    wait_cs(1'b1, 200, ok);
    check("cs_rise_timeout", ok, 1);
    if (!ok) return;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    bit   ok;
    rst_n = 1'b0;
    adc_enable = 8'h00;
    for (int i = 0; i < 8; i++) begin
      model[i] = 16'h0000;
      words[i] = 18'h0;
    end
    repeat (3) @(negedge clk);
    check("reset_cs", cs, 1);
    check("reset_convst", convst, 0);
    check("reset_sclk", sclk_enable, 0);
    check("reset_ready", adcready, 0);
    check("reset_data", adcdata, 0);
    rst_n = 1'b1;

    // Quiet while nothing is enabled.
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (convst !== 1'b0 || cs !== 1'b1 || sclk_enable !== 1'b0 || adcready !== 8'h00) bad = 1'b1;
    end
    check("idle_quiet", bad, 0);

    // Fixed patterns: A -> 16'hAAAA, B -> 16'hFFFF.
    for (int i = 0; i < 4; i++) begin
      words[i]     = 18'h2AAAA;
      words[i + 4] = 18'h3FFFC;
    end
    run_conv(8'hFF, 8'hFF);

    // Partial enable, back-to-back with the previous conversion.
    randomize_words();
    run_conv(8'h05, 8'h05);

    // Continuous enable for three conversions.
    for (int n = 0; n < 3; n++) begin
      randomize_words();
      run_conv(8'hFF, 8'hFF);
    end

    // Random enables and BUSY lengths.
    for (int n = 0; n < 6; n++) begin
      busy_len = $urandom_range(5, 40);
      randomize_words();
      run_conv(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
    end
    busy_len = 16;

    // Enable dropped mid-read: read completes, nothing published.
    randomize_words();
    run_conv(8'hFF, 8'h00);
    randomize_words();
    run_conv(8'hFF, 8'h3C);

    // Long BUSY: the bench invariants hold cs high while busy is high.
    adc_enable = 8'h00;
    repeat (200) @(negedge clk);
    busy_len = 500;
    randomize_words();
    run_conv(8'hFF, 8'hFF);
    adc_enable = 8'h00;
    busy_len = 16;
    repeat (700) @(negedge clk);

    // Reset during READ cycle 30 aborts the read; reset clears published data.
    randomize_words();
    adc_enable = 8'hFF;
    wait_cs(1'b0, 1500, ok);
    check("abort_cs_fall_timeout", ok, 1);
    repeat (31) @(negedge clk);
    check("abort_in_read", sclk_enable, 1);
    rst_n = 1'b0;
    adc_enable = 8'h00;
    @(negedge clk);
    check("abort_cs", cs, 1);
    check("abort_sclk", sclk_enable, 0);
    check("abort_ready", adcready, 0);
    check("abort_data", adcdata, 0);
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    randomize_words();
    run_conv(8'hFF, 8'hFF);
    adc_enable = 8'h00;

    repeat (400) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
